// File: rtl/eq_result_checker_pkg.sv
// Shared types and defaults for the expected-vs-result checker.
package eq_result_checker_pkg;

    localparam int unsigned DEF_WIDTH = 1;
    localparam int unsigned DEF_DEPTH = 8;
    localparam int unsigned DEF_CNT_W = 16;

    // Run-control state encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // FIFO pointer width: one extra wrap bit to tell full from empty
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/eq_result_checker_sync_fifo.sv
// Expected-value FIFO that absorbs DUT latency; flush empties it in one edge.
module eq_result_checker_sync_fifo
    import eq_result_checker_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    input  logic             flush,
    output logic             full_c,
    output logic             empty_c,
    output logic [WIDTH-1:0] head_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_w(DEPTH);

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; flush wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full_c) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop && !empty_c) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (push && !full_c && !flush) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/eq_result_checker.sv
// In-order checker: buffers expected values, compares against DUT results, reports errors.
module eq_result_checker
    import eq_result_checker_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_vectors,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             underrun,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] pushed_q, pushed_d;
    logic [CNT_W-1:0] checked_q, checked_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic             underrun_q, underrun_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_c;

    logic             fifo_push, fifo_pop, fifo_flush;
    logic             fifo_full_c, fifo_empty_c;
    logic [WIDTH-1:0] fifo_head_c;

    eq_result_checker_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .data_in (exp_data),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .head_c  (fifo_head_c)
    );

    // Accept expected values only while running, with room, and below the vector budget
    assign exp_ready = (state_q == ST_RUN) && !fifo_full_c && (pushed_q < n_q);

    // Next-state, counters, compare and flag logic
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        pushed_d   = pushed_q;
        checked_d  = checked_q;
        err_d      = err_q;
        first_d    = first_q;
        underrun_d = underrun_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        fail_c     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    n_d        = n_vectors;
                    pushed_d   = '0;
                    checked_d  = '0;
                    err_d      = '0;
                    first_d    = '0;
                    underrun_d = 1'b0;
                    fifo_flush = 1'b1;
                    state_d    = (n_vectors == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                fifo_push = exp_valid && exp_ready;
                if (fifo_push) pushed_d = pushed_q + CNT_W'(1);
                if (res_valid) begin
                    checked_d = checked_q + CNT_W'(1);
                    // No bypass: a same-cycle push does not rescue an empty FIFO
                    if (fifo_empty_c) begin
                        underrun_d = 1'b1;
                        fail_c     = 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                        fail_c   = (fifo_head_c != res_data);
                    end
                    if (fail_c) begin
                        if (err_q != '1) err_d = err_q + CNT_W'(1);
                        if (err_q == '0) first_d = checked_q;
                    end
                    if (checked_d == n_q) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == '0) && !underrun_d;
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            pushed_q   <= '0;
            checked_q  <= '0;
            err_q      <= '0;
            first_q    <= '0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            pushed_q   <= pushed_d;
            checked_q  <= checked_d;
            err_q      <= err_d;
            first_q    <= first_d;
            underrun_q <= underrun_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign underrun      = underrun_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_eq_result_checker.sv
// Scoreboard bench: stimulus queues expected run reports, a monitor checks them when done appears.
module tb_eq_result_checker;

    localparam int unsigned WIDTH = 1;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] n_vectors;
    logic             exp_valid;
    logic             exp_ready;
    logic [WIDTH-1:0] exp_data;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             busy, done, pass, underrun;
    logic [CNT_W-1:0] err_count, first_err_idx;

    typedef struct {
        logic [CNT_W-1:0] err;
        logic [CNT_W-1:0] first;
        logic             pass;
        logic             und;
    } report_t;

    report_t sb[$];
    int      total = 0;
    int      bad   = 0;
    bit      pending = 1'b0;

    eq_result_checker #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .n_vectors     (n_vectors),
        .exp_valid     (exp_valid),
        .exp_ready     (exp_ready),
        .exp_data      (exp_data),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .underrun      (underrun),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic expect_report(input int e, input int f, input bit p, input bit u);
        report_t r;
        r.err   = CNT_W'(e);
        r.first = CNT_W'(f);
        r.pass  = p;
        r.und   = u;
        sb.push_back(r);
    endtask

    // Monitor: a start accepted outside RUN arms one report check, taken when done is seen
    always @(negedge clk) begin
        report_t r;
        if (pending && done) begin
            pending = 1'b0;
            if (sb.size() == 0) begin
                chk("unexpected_report", 1, 0);
            end else begin
                r = sb.pop_front();
                chk("err_count", 32'(err_count), 32'(r.err));
                chk("first_err_idx", 32'(first_err_idx), 32'(r.first));
                chk("pass", 32'(pass), 32'(r.pass));
                chk("underrun", 32'(underrun), 32'(r.und));
            end
        end
        if (rst_n && start && !busy) pending = 1'b1;
    end

    // Drive one run: bit i of ev/rv is vector i; results start at cycle rs, one per cycle
    task automatic run_vec(input int n, input int nexp, input logic [15:0] ev,
                           input int nres, input logic [15:0] rv, input int rs,
                           input int poke, output int stalls);
        int  ei, rj, cyc;
        bit  acc;
        ei = 0; rj = 0; cyc = 0; stalls = 0;
        start = 1'b1;
        n_vectors = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        while ((ei < nexp || rj < nres) && cyc < 300) begin
            exp_valid = (ei < nexp);
            exp_data  = exp_valid ? ev[ei] : 1'b0;
            res_valid = (cyc >= rs) && (rj < nres);
            res_data  = res_valid ? rv[rj] : 1'b0;
            start     = (cyc == poke);
            n_vectors = start ? CNT_W'(1) : CNT_W'(n);
            acc = exp_valid && exp_ready;
            if (exp_valid && !exp_ready) stalls++;
            @(posedge clk); #1;
            if (acc) ei++;
            if (res_valid) rj++;
            cyc++;
            if (poke >= 0 && cyc == poke + 3) chk("busy_after_ignored_start", 32'(busy), 1);
        end
        exp_valid = 1'b0;
        res_valid = 1'b0;
        start     = 1'b0;
        if (cyc >= 300) chk("run_timeout", 1, 0);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_seen", 32'(done), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int st;
        rst_n = 1'b0; start = 1'b0; n_vectors = '0;
        exp_valid = 1'b0; exp_data = '0; res_valid = 1'b0; res_data = '0;
        #2;
        chk("rst0_exp_ready", 32'(exp_ready), 0);
        chk("rst0_busy", 32'(busy), 0);
        chk("rst0_done", 32'(done), 0);
        chk("rst0_err", 32'(err_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-run after one mismatch
        start = 1'b1; n_vectors = CNT_W'(4);
        @(posedge clk); #1;
        start = 1'b0; exp_valid = 1'b1; exp_data = 1'b1;
        @(posedge clk); #1;
        exp_valid = 1'b0; res_valid = 1'b1; res_data = 1'b0;
        @(posedge clk); #1;
        res_valid = 1'b0;
        chk("pre_reset_err", 32'(err_count), 1);
        chk("pre_reset_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_exp_ready", 32'(exp_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_first", 32'(first_err_idx), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean run, results 2 cycles behind
        expect_report(0, 0, 1'b1, 1'b0);
        run_vec(4, 4, 16'b1101, 4, 16'b1101, 2, -1, st);
        wait_done();

        // Result index 2 flipped
        expect_report(1, 2, 1'b0, 1'b0);
        run_vec(4, 4, 16'b1101, 4, 16'b1001, 2, -1, st);
        wait_done();

        // Results in DONE are ignored
        res_valid = 1'b1; res_data = 1'b0;
        repeat (3) @(posedge clk);
        #1 res_valid = 1'b0;
        chk("done_ignores_res", 32'(err_count), 1);

        // First result races its own push: underrun, second result matches exp0
        expect_report(1, 0, 1'b0, 1'b1);
        run_vec(2, 2, 16'b01, 2, 16'b10, 0, -1, st);
        wait_done();

        // FIFO fills with results held off 10 cycles
        expect_report(0, 0, 1'b1, 1'b0);
        run_vec(10, 10, 16'b1011001101, 10, 16'b1011001101, 10, -1, st);
        chk("full_stall_cycles", 32'(st), 3);
        wait_done();

        // Zero-length run
        expect_report(0, 0, 1'b1, 1'b0);
        run_vec(0, 0, 16'b0, 0, 16'b0, 0, -1, st);
        wait_done();

        // Start during RUN with a different n is ignored
        expect_report(0, 0, 1'b1, 1'b0);
        run_vec(3, 3, 16'b011, 3, 16'b011, 2, 1, st);
        wait_done();

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
